sc_frame_loader: RTL and testbench

Parametrised slow-control transmitter for MAROC-type front-end chips. It is the successor to the fixed 829-bit shifter. The frame width, serial clock rate and reset pulse length are parameters, and the block adds a start/busy/done handshake. An optional verify pass re-shifts the frame and compares the chip's returned Q_SC stream bit-for-bit. It sits between the configuration register file and the chip's D_SC/CK_SC/RSTn_SC/Q_SC pins.

---
 rtl/sc_frame_loader.sv | 201 ++++++++++++++++++++
 tb/tb_sc_frame_loader.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_frame_loader.sv
// sc_frame_loader
// Slow-control transmitter for MAROC-type front-end chips. It captures a
// configuration frame, pulses the chip's SC reset, then shifts the frame out
// LSB first on D_SC/CK_SC. An optional second pass re-shifts the same frame
// while comparing the chip's returned Q_SC stream against it, bit by bit.
//
// Handshake: start is looked at only while the block is idle (busy=0 and not
// in the done cycle). Once accepted, busy stays high until the cycle in which
// done pulses for exactly one cycle. A start that arrives while busy is
// dropped, not queued. err/err_idx describe the last finished transaction and
// are cleared when the next start is accepted.
//
// Every output is driven straight from a flop. The flop inputs are computed
// from the next-state values, so the pins change on the same clock edge as
// the FSM does.
module sc_frame_loader #(
  parameter int FRAME_W = 829,
  parameter int DIV     = 4,
  parameter int RST_CYC = 8,
  parameter int CW      = $clog2(FRAME_W)
) (
  input  logic               CK_in,
  input  logic               rst,
  input  logic               start,
  input  logic               verify,
  input  logic [FRAME_W-1:0] frame,
  input  logic               Q_SC,
  output logic               D_SC,
  output logic               CK_SC,
  output logic               RSTn_SC,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CW-1:0]      err_idx,
  output logic [2:0]         dbg_state
);

  // FSM encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RST    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_VERIFY = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // One bit period is 2*DIV CK_in cycles. The first DIV cycles have CK_SC low
  // and the last DIV cycles have CK_SC high.
  localparam int PW = $clog2(2 * DIV);
  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  localparam logic [PW-1:0] PH_RISE     = PW'(DIV);
  localparam logic [PW-1:0] PH_PRE_RISE = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_LAST     = PW'(2 * DIV - 1);
  localparam logic [CW-1:0] BIT_LAST    = CW'(FRAME_W - 1);
  localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYC - 1);

  // Control state
  logic [2:0]         state_q,   state_d;
  logic [RW-1:0]      rst_cnt_q, rst_cnt_d;
  logic [PW-1:0]      phase_q,   phase_d;
  logic [CW-1:0]      bit_q,     bit_d;
  logic [FRAME_W-1:0] shadow_q,  shadow_d;
  logic               verify_q,  verify_d;

  // Registered outputs
  logic               d_sc_q,    d_sc_d;
  logic               ck_sc_q,   ck_sc_d;
  logic               rstn_sc_q, rstn_sc_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic               err_q,     err_d;
  logic [CW-1:0]      err_idx_q, err_idx_d;

  logic shifting_d;
  logic last_phase;
  logic last_bit;
  logic q_mismatch;

  assign last_phase = (phase_q == PH_LAST);
  assign last_bit   = (bit_q == BIT_LAST);
  // Q_SC is compared on the CK_in edge where CK_SC rises. The chip has not
  // shifted yet at that edge, so Q_SC still shows the bit for this index.
  assign q_mismatch = (phase_q == PH_PRE_RISE) && (Q_SC != shadow_q[bit_q]);

  // Next-state logic: sequencing, frame capture and verify comparison
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shadow_d  = shadow_q;
    verify_d  = verify_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Capture the frame so that later changes on the frame bus cannot
          // corrupt a transfer that is already running.
          shadow_d  = frame;
          verify_d  = verify;
          err_d     = 1'b0;
          err_idx_d = '0;
          rst_cnt_d = '0;
          state_d   = S_RST;
        end
      end

      S_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          phase_d = '0;
          bit_d   = '0;
          state_d = S_LOAD;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      S_LOAD, S_VERIFY: begin
        // Only the first mismatch is recorded. Later ones leave err_idx alone.
        if ((state_q == S_VERIFY) && q_mismatch && !err_q) begin
          err_d     = 1'b1;
          err_idx_d = bit_q;
        end
        if (last_phase) begin
          phase_d = '0;
          if (last_bit) begin
            // The bit index wraps straight into the verify pass with no gap.
            bit_d   = '0;
            state_d = ((state_q == S_LOAD) && verify_q) ? S_VERIFY : S_DONE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from next state, so every pin is a flop output
  always_comb begin
    shifting_d = (state_d == S_LOAD) || (state_d == S_VERIFY);
    d_sc_d     = shifting_d ? shadow_d[bit_d] : 1'b0;
    ck_sc_d    = shifting_d && (phase_d >= PH_RISE);
    rstn_sc_d  = (state_d != S_RST);
    busy_d     = (state_d == S_RST) || shifting_d;
    done_d     = (state_d == S_DONE);
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge CK_in or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= '0;
      phase_q   <= '0;
      bit_q     <= '0;
      shadow_q  <= '0;
      verify_q  <= 1'b0;
      d_sc_q    <= 1'b0;
      ck_sc_q   <= 1'b0;
      rstn_sc_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shadow_q  <= shadow_d;
      verify_q  <= verify_d;
      d_sc_q    <= d_sc_d;
      ck_sc_q   <= ck_sc_d;
      rstn_sc_q <= rstn_sc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign D_SC      = d_sc_q;
  assign CK_SC     = ck_sc_q;
  assign RSTn_SC   = rstn_sc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_idx   = err_idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sc_frame_loader.sv
// Testbench for sc_frame_loader. It drives random and directed frames into a
// 16-bit instance that is connected to a shift-register chip model, and it
// also runs one load-only transfer through a default-sized instance.
module tb_sc_frame_loader;

  localparam int FW  = 16;
  localparam int DV  = 2;
  localparam int RC  = 4;
  localparam int CWS = $clog2(FW);
  localparam int BFW = 829;
  localparam int BDV = 4;
  localparam int BRC = 8;
  localparam int BCW = $clog2(BFW);
  localparam int NONE = 1000;

  // ---------------- clock / reset ----------------
  logic CK_in = 1'b0;
  logic rst   = 1'b1;
  always #5 CK_in = ~CK_in;

  int cyc = 0;
  always @(posedge CK_in) cyc <= cyc + 1;

  // ---------------- small DUT ----------------
  logic          start = 1'b0, verify = 1'b0;
  logic [FW-1:0] frame = '0;
  logic          Q_SC;
  logic          D_SC, CK_SC, RSTn_SC, busy, done, err;
  logic [CWS-1:0] err_idx;
  logic [2:0]    dbg_state;

  sc_frame_loader #(.FRAME_W(FW), .DIV(DV), .RST_CYC(RC)) dut (
    .CK_in(CK_in), .rst(rst), .start(start), .verify(verify), .frame(frame),
    .Q_SC(Q_SC), .D_SC(D_SC), .CK_SC(CK_SC), .RSTn_SC(RSTn_SC), .busy(busy),
    .done(done), .err(err), .err_idx(err_idx), .dbg_state(dbg_state)
  );

  // ---------------- default-sized DUT ----------------
  logic           start_b = 1'b0;
  logic [BFW-1:0] frame_b = '0;
  logic           q_sc_b  = 1'b0;
  logic           d_sc_b, ck_sc_b, rstn_sc_b, busy_b, done_b, err_b;
  logic [BCW-1:0] err_idx_b;
  logic [2:0]     dbg_state_b;

  sc_frame_loader dut_big (
    .CK_in(CK_in), .rst(rst), .start(start_b), .verify(1'b0), .frame(frame_b),
    .Q_SC(q_sc_b), .D_SC(d_sc_b), .CK_SC(ck_sc_b), .RSTn_SC(rstn_sc_b),
    .busy(busy_b), .done(done_b), .err(err_b), .err_idx(err_idx_b),
    .dbg_state(dbg_state_b)
  );

  // ---------------- chip model ----------------
  logic [FW-1:0] chip_sr = '0;
  int rise_cnt  = 0;
  int rise_base = 0;
  int inj_a = NONE, inj_b = NONE;
  logic inj_hit;

  always @(posedge CK_SC) begin
    chip_sr  <= {D_SC, chip_sr[FW-1:1]};
    rise_cnt <= rise_cnt + 1;
  end
  assign inj_hit = ((rise_cnt - rise_base) == FW + inj_a) ||
                   ((rise_cnt - rise_base) == FW + inj_b);
  assign Q_SC = chip_sr[0] ^ inj_hit;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [32:0]  exp_q[$];        // {rise cycle relative to t0, expected D_SC}
  int           exp_done_q[$];   // done cycle relative to t0
  logic [CWS:0] exp_err_q[$];    // {err, err_idx}

  bit tx_active = 1'b0;
  int t0 = 0;
  int tx_done_rel = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor ----------------
  logic         ck_prev = 1'b0;
  int           mon_rel;
  logic [32:0]  mon_e;
  logic [CWS:0] mon_ee;
  int           mon_dr;

  always @(posedge CK_in) begin
    #1;
    if (tx_active) begin
      mon_rel = cyc - t0;
      check("rstn_sc", 64'(RSTn_SC), 64'(mon_rel >= RC));
      check("busy", 64'(busy), 64'(mon_rel < tx_done_rel));
      if (mon_rel == 0) begin
        check("err_cleared", 64'(err), 64'(0));
        check("err_idx_cleared", 64'(err_idx), 64'(0));
      end
      if (CK_SC && !ck_prev) begin
        if (exp_q.size() == 0) fail_now("unexpected_ck_sc_rise");
        else begin
          mon_e = exp_q.pop_front();
          check("rise_time", 64'(mon_rel), 64'(mon_e[32:1]));
          check("d_sc_bit", 64'(D_SC), 64'(mon_e[0]));
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) fail_now("done_without_expectation");
        else begin
          mon_dr = exp_done_q.pop_front();
          mon_ee = exp_err_q.pop_front();
          check("done_time", 64'(mon_rel), 64'(mon_dr));
          check("err", 64'(err), 64'(mon_ee[CWS]));
          check("err_idx", 64'(err_idx), 64'(mon_ee[CWS-1:0]));
          check("bits_left", 64'(exp_q.size()), 64'(0));
        end
        exp_q.delete();
        tx_active = 1'b0;
      end else if (mon_rel > tx_done_rel) begin
        fail_now("done_timeout");
        exp_q.delete();
        exp_done_q.delete();
        exp_err_q.delete();
        tx_active = 1'b0;
      end
    end else if (done) begin
      fail_now("unexpected_done");
    end
    ck_prev = CK_SC;
  end

  // ---------------- driver tasks ----------------
  // Issue one transaction and push its expected response, as derived from
  // the frame, verify flag and the bits the chip model will corrupt.
  task automatic issue_tx(input logic [FW-1:0] f, input logic v, input int ia, input int ib);
    int n;
    int p_cnt;
    int first;
    logic r;
    n = 0;
    @(negedge CK_in);
    while ((busy || done || tx_active) && n < 4000) begin
      @(negedge CK_in);
      n++;
    end
    if (n >= 4000) fail_now("idle_timeout");
    p_cnt = v ? 2 : 1;
    t0 = cyc + 1;
    tx_done_rel = RC + p_cnt * FW * 2 * DV;
    for (int p = 0; p < p_cnt; p++)
      for (int k = 0; k < FW; k++)
        exp_q.push_back({32'(RC + (p * FW + k) * 2 * DV + DV), f[k]});
    first = -1;
    for (int k = 0; k < FW; k++) begin
      r = f[k] ^ ((k == ia) || (k == ib));
      if ((r != f[k]) && (first < 0)) first = k;
    end
    exp_done_q.push_back(tx_done_rel);
    exp_err_q.push_back((v && first >= 0) ? {1'b1, CWS'(first)} : '0);
    inj_a = ia;
    inj_b = ib;
    rise_base = rise_cnt;
    frame = f;
    verify = v;
    start = 1'b1;
    tx_active = 1'b1;
    @(negedge CK_in);
    start  = 1'b0;
    frame  = 16'($urandom);
    verify = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_tx();
    int n;
    n = 0;
    while (tx_active && n < 4000) begin
      @(negedge CK_in);
      n++;
    end
    if (tx_active) begin
      fail_now("wait_tx_timeout");
      tx_active = 1'b0;
    end
  endtask

  task automatic run_tx(input logic [FW-1:0] f, input logic v, input int ia, input int ib);
    issue_tx(f, v, ia, ib);
    wait_tx();
  endtask

  // ---------------- default-sized check ----------------
  task automatic run_big();
    logic [BFW-1:0] f;
    logic [BFW-1:0] cap;
    int nb, n, tb0, bad;
    logic prev;
    for (int i = 0; i < BFW; i++) f[i] = 1'($urandom);
    cap = '0;
    nb = 0;
    prev = 1'b0;
    @(negedge CK_in);
    frame_b = f;
    start_b = 1'b1;
    tb0 = cyc + 1;
    @(negedge CK_in);
    start_b = 1'b0;
    frame_b = '0;
    n = 0;
    while (n < 8000) begin
      @(posedge CK_in);
      #1;
      if (ck_sc_b && !prev) begin
        if (nb < BFW) cap[nb] = d_sc_b;
        nb++;
      end
      prev = ck_sc_b;
      if (done_b) break;
      n++;
    end
    if (!done_b) fail_now("big_done_timeout");
    check("big_done_time", 64'(cyc - tb0), 64'(BRC + BFW * 2 * BDV));
    check("big_rise_count", 64'(nb), 64'(BFW));
    bad = 0;
    for (int i = 0; i < BFW; i++) if (cap[i] !== f[i]) bad++;
    check("big_bits_bad", 64'(bad), 64'(0));
    check("big_err", 64'(err_b), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [FW-1:0] f;
    logic v;
    int ia, ib;

    // Reset applied with no clock edge yet
    #1 rst = 1'b0;
    #1;
    check("rst_d_sc", 64'(D_SC), 64'(0));
    check("rst_ck_sc", 64'(CK_SC), 64'(0));
    check("rst_rstn_sc", 64'(RSTn_SC), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_err_idx", 64'(err_idx), 64'(0));
    @(negedge CK_in);
    @(negedge CK_in);
    rst = 1'b1;

    // Load only
    run_tx(16'hA5C3, 1'b0, NONE, NONE);

    // Verify, clean chip
    run_tx(16'h3C5A, 1'b1, NONE, NONE);
    check("chip_contents", 64'(chip_sr), 64'(16'h3C5A));

    // Verify with corrupted bits 5 and 9, then a clean run clears err
    run_tx(16'hFFFF, 1'b1, 5, 9);
    run_tx(16'($urandom), 1'b1, NONE, NONE);

    // Start pulses during LOAD and during the done cycle are ignored
    issue_tx(16'hA5C3, 1'b0, NONE, NONE);
    repeat (RC + 6) @(negedge CK_in);
    start = 1'b1;
    frame = 16'h0000;
    @(negedge CK_in);
    start = 1'b0;
    n = 0;
    while ((cyc < t0 + tx_done_rel) && n < 4000) begin
      @(negedge CK_in);
      n++;
    end
    start = 1'b1;
    @(negedge CK_in);
    start = 1'b0;
    check("start_in_done_ignored", 64'(busy), 64'(0));
    wait_tx();
    repeat (4) @(negedge CK_in);

    // Randomized transactions
    for (int i = 0; i < 8; i++) begin
      f  = 16'($urandom);
      v  = 1'($urandom_range(0, 1));
      ia = ($urandom_range(0, 2) == 0) ? NONE : int'($urandom_range(0, FW - 1));
      ib = ($urandom_range(0, 2) == 0) ? NONE : int'($urandom_range(0, FW - 1));
      run_tx(f, v, ia, ib);
    end

    // Reset during VERIFY bit 7 while CK_SC is high
    issue_tx(16'($urandom), 1'b1, NONE, NONE);
    n = 0;
    while (n < 4000) begin
      @(posedge CK_in);
      #3;
      if (CK_SC && ((rise_cnt - rise_base) == FW + 8)) break;
      n++;
    end
    if (n >= 4000) fail_now("mid_reset_point_not_reached");
    rst = 1'b0;
    tx_active = 1'b0;
    exp_q.delete();
    exp_done_q.delete();
    exp_err_q.delete();
    #1;
    check("mid_rst_ck_sc", 64'(CK_SC), 64'(0));
    check("mid_rst_d_sc", 64'(D_SC), 64'(0));
    check("mid_rst_rstn_sc", 64'(RSTn_SC), 64'(1));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_err", 64'(err), 64'(0));
    check("mid_rst_err_idx", 64'(err_idx), 64'(0));
    @(negedge CK_in);
    @(negedge CK_in);
    rst = 1'b1;
    run_tx(16'h1234, 1'b1, NONE, NONE);

    // Default parameters, load only
    run_big();

    repeat (4) @(negedge CK_in);
    check("scoreboard_empty", 64'(exp_q.size() + exp_done_q.size() + exp_err_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
